// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: NUM_CH x WIDTH pipeline register; all channels move together as one entry.
// Latency: an accepted entry shows on out_data after the accepting edge (one cycle later with the stage not blocked).
// Backpressure: PIPE_STAGE_SKID_BUF_EN defined -> 2 entries (main + skid), in_ready independent of out_ready;
//               undefined -> 1 entry, in_ready = (~out_valid | out_ready) & en & ~flush (combinational).
module pipe_stage_skid #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 2   // legal range 1..8
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    en,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [1:0]              occupancy
);

  localparam int DW = NUM_CH * WIDTH;

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic          in_fire;
  logic          out_fire;

  assign in_fire  = in_valid & in_ready & en;
  assign out_fire = out_valid & out_ready & en;
  assign out_data = main_q;

`ifdef PIPE_STAGE_SKID_BUF_EN

  logic [DW-1:0] skid_q, skid_d;

  // Outputs decoded from state only; in_ready never depends on out_ready here.
  always_comb begin
    out_valid = (state_q != S_EMPTY);
    occupancy = state_q;
    in_ready  = (state_q != S_TWO) & ~flush & ~srst;
  end

  // Next state and datapath: flush empties the stage, otherwise handshake-driven moves.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d = S_ONE;
            main_d  = in_data;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = S_TWO;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          // The skid entry is older than anything upstream, so it refills main first.
          if (out_fire) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  // Skid register; reset overrides everything else.
  always_ff @(posedge clk) begin
    if (srst) begin
      skid_q <= '0;
    end else begin
      skid_q <= skid_d;
    end
  end

`else

  // Outputs: single-entry stage can only accept when it is empty or draining this cycle.
  always_comb begin
    out_valid = (state_q != S_EMPTY);
    occupancy = state_q;
    in_ready  = ((state_q == S_EMPTY) | out_ready) & en & ~flush & ~srst;
  end

  // Next state and datapath: in ONE an accept always coincides with an emit.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d = S_ONE;
            main_d  = in_data;
          end
        end
        S_ONE: begin
          if (in_fire) begin
            main_d = in_data;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

`endif

  // State and main register; reset has priority over flush and handshakes.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: random + directed traffic against a bounded-queue model of the stage.
// Driver issues one cycle of inputs and records the model's expectations; monitor checks on the falling edge.
// Works for both the one-entry and the two-entry build.
module tb_pipe_stage_skid;

  localparam int WIDTH  = 32;
  localparam int NUM_CH = 2;
  localparam int DW     = WIDTH * NUM_CH;
`ifdef PIPE_STAGE_SKID_BUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  pipe_stage_skid #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk       (clk),
    .srst      (srst),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Model: entries held by the stage, oldest first.
  logic [DW-1:0] sb_q[$];
  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit known = 1'b0;       // a reset edge has been seen
  bit zero_state = 1'b0;  // nothing accepted since the last reset/flush
  // Expectations for the cycle currently being driven.
  bit exp_known = 1'b0;
  bit exp_zero = 1'b0;
  bit exp_in_ready = 1'b0;
  int exp_occ = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle and advance the model across the coming edge.
  task automatic cyc(input bit r, input bit e, input bit f, input bit iv,
                     input logic [DW-1:0] d, input bit ordy);
    srst      = r;
    en        = e;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    exp_known = known;
    exp_zero  = zero_state;
    exp_occ   = sb_q.size();
`ifdef PIPE_STAGE_SKID_BUF_EN
    exp_in_ready = (exp_occ < CAP) && !f && !r;
`else
    exp_in_ready = (exp_occ == 0 || ordy) && e && !f && !r;
`endif
    if (r || f) begin
      sb_q.delete();
      zero_state = 1'b1;
    end else if (iv && exp_in_ready && e) begin
      sb_q.push_back(d);
      zero_state = 1'b0;
    end
    if (r) known = 1'b1;
    n_vec++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare control outputs each cycle, retire the head entry when the DUT emits.
  always @(negedge clk) begin
    if (n_vec > 0) begin
      chk("in_ready", DW'(in_ready), DW'(exp_in_ready));
      if (exp_known) begin
        chk("out_valid", DW'(out_valid), DW'(exp_occ != 0));
        chk("occupancy", DW'(occupancy), DW'(exp_occ));
        if (exp_zero) chk("out_data_cleared", out_data, '0);
        if (exp_occ != 0 && sb_q.size() != 0) chk("out_data", out_data, sb_q[0]);
        if (out_valid === 1'b1 && out_ready && en && !flush && !srst) begin
          if (sb_q.size() != 0) void'(sb_q.pop_front());
          else chk("emit_while_empty", DW'(out_valid), '0);
        end
      end
    end
  end

  initial begin
    // Reset held for two cycles, then idle.
    cyc(1, 0, 0, 0, '0, 0);
    cyc(1, 0, 0, 0, '0, 0);
    cyc(0, 1, 0, 0, '0, 0);

    // Back-to-back streaming with downstream always ready.
    cyc(0, 1, 0, 1, 64'h00000001_00000002, 1);
    cyc(0, 1, 0, 1, 64'h00000003_00000004, 1);
    cyc(0, 1, 0, 0, '0, 1);
    cyc(0, 1, 0, 0, '0, 1);

    // Blocked downstream: fill, then release.
    cyc(0, 1, 0, 1, 64'h11, 0);
    cyc(0, 1, 0, 1, 64'h22, 0);
    cyc(0, 1, 0, 0, '0, 0);
    cyc(0, 1, 0, 0, '0, 1);
    cyc(0, 1, 0, 0, '0, 1);
    cyc(0, 1, 0, 0, '0, 1);

    // Flush with concurrent input and ready.
    cyc(0, 1, 0, 1, 64'h33, 0);
    cyc(0, 1, 0, 1, 64'h44, 0);
    cyc(0, 1, 1, 1, 64'h99, 1);
    cyc(0, 1, 0, 0, '0, 0);

    // Stage disabled while holding one entry.
    cyc(0, 1, 0, 1, 64'h66, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 64'h77, 1);
    cyc(0, 1, 0, 1, 64'h88, 1);
    cyc(0, 1, 0, 0, '0, 1);
    cyc(0, 1, 0, 0, '0, 1);

    // Single entry blocked, then ready raised.
    cyc(0, 1, 0, 1, 64'h55, 0);
    cyc(0, 1, 0, 0, '0, 0);
    cyc(0, 1, 0, 0, '0, 1);
    cyc(0, 1, 0, 0, '0, 1);

    // Randomised traffic, including occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 99) < 85,
          $urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < 70,
          {$urandom, $urandom},
          $urandom_range(0, 99) < 60);
    end

    // Drain whatever is left and confirm every accepted entry came out.
    for (int i = 0; i < 2 * CAP + 4; i++) cyc(0, 1, 0, 0, '0, 1);
    chk("drained", DW'(sb_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter WIDTH, default 32, bit width of one data channel.
REQ-002 Parameter NUM_CH, default 2, number of data channels, legal range 1..8.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port srst  input  1  synchronous reset, active-high.
REQ-005 Port en  input  1  stage enable; when 0, no transfer occurs on either side.
REQ-006 Port flush  input  1  synchronous discard of all held entries.
REQ-007 Port in_valid  input  1  upstream offers data.
REQ-008 Port in_ready  output  1  stage accepts data.
REQ-009 Port in_data  input  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 Port out_valid  output  1  stage presents data.
REQ-011 Port out_ready  input  1  downstream accepts data.
REQ-012 Port out_data  output  NUM_CH*WIDTH  same channel packing as in_data.
REQ-013 Port occupancy  output  2  number of held entries, 0..2.

Function
REQ-014 in_fire = in_valid & in_ready & en; out_fire = out_valid & out_ready & en; transfers occur only on fire.
REQ-015 Storage: main register (drives out_data) plus skid register; all NUM_CH channels move together as one entry.
REQ-016 States: EMPTY (occupancy 0), ONE (1), TWO (2); out_valid = (state != EMPTY).
REQ-017 in_ready = (state != TWO) & ~flush, registered (no combinational path from out_ready).
REQ-018 EMPTY: in_fire -> ONE, main <= in_data; otherwise stay.
REQ-019 ONE: in_fire & out_fire -> ONE, main <= in_data; in_fire only -> TWO, skid <= in_data; out_fire only -> EMPTY; neither -> stay.
REQ-020 TWO: out_fire -> ONE, main <= skid; otherwise stay, registers hold.
REQ-021 Latency: entry accepted at edge N is visible on out_data after edge N when stage was EMPTY or ONE with simultaneous out_fire; order is strictly FIFO, no entry dropped or duplicated.
REQ-022 en=0: state and registers hold; in_ready and out_valid still reflect state.
REQ-023 flush=1: next state EMPTY, main and skid <= 0, regardless of en, in_valid, out_ready; concurrent in_valid discarded.
REQ-024 Priority: srst > flush > handshake transitions.
REQ-025 out_data holds its value whenever out_valid=1 and out_fire=0.

Reset
REQ-026 srst=1 at a rising edge: state EMPTY, main and skid 0, out_valid 0, occupancy 0, out_data 0.
REQ-027 in_ready is 0 during the cycle srst is asserted and 1 in the first cycle after deassertion.
REQ-028 Reset mid-operation discards both held entries; no partial transfer completes on that edge.

Configuration
REQ-029 Macro PIPE_STAGE_SKID_BUF_EN defined: behaviour per REQ-015..REQ-025 with two-entry storage.
REQ-030 Macro PIPE_STAGE_SKID_BUF_EN undefined: skid register and TWO state are not built; in_ready = (~out_valid | out_ready) & en & ~flush (combinational); ONE with in_fire & ~out_fire cannot occur; occupancy max 1; all other rules unchanged.

Verification
REQ-031 srst=1 for 2 cycles, then release -> out_valid 0, occupancy 0, out_data 0, in_ready 1 in the next cycle.
REQ-032 WIDTH=32, NUM_CH=2, out_ready=1, en=1, stream in_data 0x00000001_00000002 then 0x00000003_00000004 back-to-back -> out_data shows each one cycle after acceptance, occupancy stays 1.
REQ-033 out_ready=0, push A=0x11, B=0x22 (skid build) -> occupancy 2, in_ready 0; raise out_ready -> out_data A then B on consecutive cycles.
REQ-034 Occupancy 2, flush=1 with in_valid=1 and out_ready=1 -> next cycle occupancy 0, out_valid 0, out_data 0, no entry emitted or accepted.
REQ-035 Occupancy 1, en=0 with in_valid=1 and out_ready=1 for 3 cycles -> state, out_data, occupancy unchanged; en=1 resumes ordered flow.
REQ-036 Macro undefined, out_ready=0, push 0x55 -> in_ready 0 next cycle; set out_ready=1 -> in_ready 1 in the same cycle, 0x55 emitted.
